pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//  Instruction-side sequencer that consumes the controller's decoded outputs (jump, branch, halted)
//  plus datapath compare/register results, and drives the next fetch.
//  - Owns the PC; runs a fetch/issue/resolve loop against instruction memory over a req/ack handshake.
//  - Presents each fetched word to the controller/datapath.
//  - Enters a terminal HALT state on syscall or alignment fault.
// PARAMETERS
//  RESET_PC     32'h0000_0000  PC loaded on reset; first fetch address
//  ALIGN_CHECK  1              1: misaligned next PC (bits[1:0]!=0) forces HALT with fault=1; 0: bits[1:0] forced to 00
// PORTS
//  clk          in   1   rising-edge clock
//  rst_b        in   1   asynchronous active-low reset
//  imem_req     out  1   fetch request; held until imem_ack
//  imem_addr    out  32  fetch address (= pc while imem_req)
//  imem_ack     in   1   fetch complete; imem_rdata valid this cycle
//  imem_rdata   in   32  fetched instruction word
//  inst_valid   out  1   inst holds an issued instruction awaiting resolution
//  inst         out  32  issued instruction (opcode inst[31:26] and func inst[5:0] go to the controller)
//  pc           out  32  address of the issued instruction
//  link_addr    out  32  pc+4, used for the JAL writeback
//  ctl_valid    in   1   controller/datapath outputs for inst are settled
//  jump         in   1   J/JAL: absolute target
//  jump_reg     in   1   JR: target = rs_data
//  branch       in   1   conditional branch instruction
//  branch_taken in   1   ALU compare result for branch (meaningful only when branch=1)
//  halted       in   1   syscall decoded
//  rs_data      in   32  register rs value for jump_reg
//  halt         out  1   sequencer in HALT
//  fault        out  1   HALT was caused by an alignment fault
// BEHAVIOUR
//  Reset values (asynchronous):
//   pc=RESET_PC; inst=0; imem_req=0; inst_valid=0; halt=0; fault=0; state=FETCH.
//  Reset mid-operation: an outstanding request is abandoned; a late imem_ack after reset is ignored
//   unless imem_req=1.
//  FSM states: FETCH, ISSUE, HALT.
//  FETCH:
//   - imem_req=1, imem_addr=pc.
//   - On imem_ack: inst<=imem_rdata, imem_req<=0 -> ISSUE.
//   - Zero-wait ack (ack in the first req cycle) is legal; minimum 1 cycle in FETCH.
//  ISSUE:
//   - inst_valid=1; pc and inst stable; wait for ctl_valid.
//   - On ctl_valid: pc<=npc, inst_valid<=0 -> FETCH, or -> HALT as below.
//   - Minimum instruction period is 2 cycles.
//  npc priority, highest first:
//   1. halted: pc unchanged -> HALT, fault=0.
//   2. jump_reg: rs_data.
//   3. jump: {pc_plus4[31:28], inst[25:0], 2'b00}.
//   4. branch & branch_taken: pc_plus4 + {{14{inst[15]}}, inst[15:0], 2'b00}.
//   5. Otherwise: pc_plus4.
//   Any lower-priority inputs asserted together with a higher one are ignored.
//  Arithmetic: all PC arithmetic is modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 32'h0000_0000
//   (no fault). Branch offsets are signed and may go backward.
//  Alignment: applies to the jump_reg result only (other targets are aligned by construction).
//   ALIGN_CHECK=1: pc unchanged, fault<=1, -> HALT.
//  HALT:
//   - halt=1; imem_req=0; inst_valid=0; pc frozen.
//   - Absorbing state: only rst_b leaves it; ctl_valid and imem_ack are ignored.
//  ctl_valid outside ISSUE is ignored. imem_ack outside FETCH is ignored.
// STRUCTURE
//  Shared package mips_pkg:
//   - opcode/func constants (SYSCALL=6'b001100, J=6'b000010, JAL=6'b000011, BEQ..BGEZ);
//   - seq_state_t enum {FETCH, ISSUE, HALT}; RESET_PC default.
//  Sub-module npc_calc (combinational): pc, inst, rs_data and control bits in -> npc and misalign out.
//   The FSM and registers stay in pc_sequencer.
// TESTING
//  1. Reset, zero-wait imem -> imem_addr 0,4,8 on successive fetches; 2 cycles per instruction;
//     link_addr=pc+4.
//  2. pc=0x0000_0010, branch=1, taken=1, imm=16'hFFFC -> next imem_addr=0x0000_0004;
//     same with taken=0 -> 0x0000_0014.
//  3. pc=0x1000_0000, jump=1, inst[25:0]=26'h0000040 -> imem_addr=0x1000_0100;
//     jump+branch+taken together -> jump target wins.
//  4. jump_reg, rs_data=0x0000_0102, ALIGN_CHECK=1 -> halt=1, fault=1, pc frozen, imem_req stays 0;
//     rs_data=0x200 -> fetch at 0x200.
//  5. halted=1 with jump=1 -> HALT, fault=0; later imem_ack/ctl_valid pulses change nothing;
//     RESET_PC=0xFFFF_FFFC -> second fetch at 0x0.
//  6. Assert rst_b=0 while imem_req=1 with ack delayed 3 cycles -> outputs at reset values immediately;
//     stray ack ignored; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS decode constants and sequencer types.
// Imported by the instruction-side sequencer and its next-PC logic.
package mips_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_REGIMM  = 6'b000001;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_BNE     = 6'b000101;
    localparam logic [5:0] OP_BLEZ    = 6'b000110;
    localparam logic [5:0] OP_BGTZ    = 6'b000111;
    localparam logic [4:0] RT_BLTZ    = 5'b00000;
    localparam logic [4:0] RT_BGEZ    = 5'b00001;
    localparam logic [5:0] FN_JR      = 6'b001000;
    localparam logic [5:0] FN_SYSCALL = 6'b001100;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        ISSUE = 2'd1,
        HALT  = 2'd2
    } seq_state_t;

    function automatic logic [31:0] br_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/npc_calc.sv
// Combinational next-PC selection for the sequencer.
// Syscall priority is resolved by the caller; this block only picks a target.
module npc_calc
    import mips_pkg::*;
#(
    parameter bit ALIGN_CHECK = 1'b1
) (
    input  logic [31:0] pc,
    input  logic [25:0] target,
    input  logic [31:0] rs_data,
    input  logic        jump,
    input  logic        jump_reg,
    input  logic        branch,
    input  logic        branch_taken,
    output logic [31:0] npc,
    output logic        misalign
);

    logic [31:0] pc_plus4;

    always_comb begin
        pc_plus4 = pc + 32'd4;
        npc      = pc_plus4;
        misalign = 1'b0;
        if (jump_reg) begin
            npc      = ALIGN_CHECK ? rs_data : {rs_data[31:2], 2'b00};
            misalign = ALIGN_CHECK && (rs_data[1:0] != 2'b00);
        end else if (jump) begin
            npc = {pc_plus4[31:28], target, 2'b00};
        end else if (branch && branch_taken) begin
            npc = pc_plus4 + br_offset(target[15:0]);
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Instruction-side sequencer: owns the PC and runs fetch/issue/resolve
// against instruction memory, stopping in HALT on syscall or misalignment.
module pc_sequencer
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = RESET_PC_DEF,
    parameter bit          ALIGN_CHECK = 1'b1
) (
    input  logic        clk,
    input  logic        rst_b,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] pc,
    output logic [31:0] link_addr,
    input  logic        ctl_valid,
    input  logic        jump,
    input  logic        jump_reg,
    input  logic        branch,
    input  logic        branch_taken,
    input  logic        halted,
    input  logic [31:0] rs_data,
    output logic        halt,
    output logic        fault
);

    seq_state_t  state;
    seq_state_t  next_state;
    logic [31:0] npc;
    logic        misalign;
    logic        ack_take;

    npc_calc #(
        .ALIGN_CHECK (ALIGN_CHECK)
    ) u_npc (
        .pc           (pc),
        .target       (inst[25:0]),
        .rs_data      (rs_data),
        .jump         (jump),
        .jump_reg     (jump_reg),
        .branch       (branch),
        .branch_taken (branch_taken),
        .npc          (npc),
        .misalign     (misalign)
    );

    // An ack only counts against a live request, so stray acks after reset drop out.
    assign ack_take = imem_req && imem_ack;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) state <= FETCH;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            FETCH: if (ack_take) next_state = ISSUE;
            ISSUE: begin
                if (ctl_valid)
                    next_state = (halted || misalign) ? HALT : FETCH;
            end
            HALT:    next_state = HALT;
            default: next_state = FETCH;
        endcase
    end

    always_comb begin
        inst_valid = (state == ISSUE);
        halt       = (state == HALT);
        imem_addr  = pc;
        link_addr  = pc + 32'd4;
    end

    // Request is raised on the way back into FETCH so a zero-wait memory
    // sustains a two-cycle instruction period.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            pc       <= RESET_PC;
            inst     <= '0;
            imem_req <= 1'b0;
            fault    <= 1'b0;
        end else begin
            unique case (state)
                FETCH: begin
                    if (!imem_req) begin
                        imem_req <= 1'b1;
                    end else if (imem_ack) begin
                        inst     <= imem_rdata;
                        imem_req <= 1'b0;
                    end
                end
                ISSUE: begin
                    if (ctl_valid && !halted) begin
                        if (misalign) begin
                            fault <= 1'b1;
                        end else begin
                            pc       <= npc;
                            imem_req <= 1'b1;
                        end
                    end
                end
                default: begin
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized self-checking bench for pc_sequencer against a PC-level model.
// A second instance covers the reset-vector wraparound.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst_b;
    logic        imem_req, imem_ack;
    logic [31:0] imem_addr, imem_rdata;
    logic        inst_valid;
    logic [31:0] inst, pc, link_addr, rs_data;
    logic        ctl_valid, jump, jump_reg, branch, branch_taken, halted;
    logic        halt, fault;

    logic        w_req, w_ack, w_iv, w_ctl, w_halt, w_fault;
    logic [31:0] w_addr, w_rdata, w_inst, w_pc, w_link;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;

    logic [31:0] m_pc;
    logic [31:0] m_inst;
    bit          m_halt;
    bit          m_fault;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    pc_sequencer dut (
        .clk(clk), .rst_b(rst_b),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .inst_valid(inst_valid), .inst(inst), .pc(pc),
        .link_addr(link_addr), .ctl_valid(ctl_valid),
        .jump(jump), .jump_reg(jump_reg), .branch(branch),
        .branch_taken(branch_taken), .halted(halted),
        .rs_data(rs_data), .halt(halt), .fault(fault)
    );

    pc_sequencer #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
        .clk(clk), .rst_b(rst_b),
        .imem_req(w_req), .imem_addr(w_addr),
        .imem_ack(w_ack), .imem_rdata(w_rdata),
        .inst_valid(w_iv), .inst(w_inst), .pc(w_pc),
        .link_addr(w_link), .ctl_valid(w_ctl),
        .jump(1'b0), .jump_reg(1'b0), .branch(1'b0),
        .branch_taken(1'b0), .halted(1'b0),
        .rs_data(32'h0), .halt(w_halt), .fault(w_fault)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic void model(input bit h, input bit jr, input bit j,
                                  input bit br, input bit tk,
                                  input logic [31:0] rs);
        logic [31:0] p4;
        int off;
        p4 = m_pc + 32'd4;
        off = int'($signed(m_inst[15:0]));
        if (h) m_halt = 1;
        else if (jr) begin
            if (rs % 4 != 0) begin
                m_halt = 1;
                m_fault = 1;
            end else m_pc = rs;
        end
        else if (j) m_pc = (p4 & 32'hF000_0000) + ((m_inst & 32'h03FF_FFFF) * 4);
        else if (br && tk) m_pc = p4 + 32'(off * 4);
        else m_pc = p4;
    endfunction

    task automatic do_reset();
        rst_b = 1'b0;
        #1;
        check("rst_pc", pc, 32'h0);
        check("rst_inst", inst, 32'h0);
        check("rst_req", imem_req, 0);
        check("rst_valid", inst_valid, 0);
        check("rst_halt", halt, 0);
        check("rst_fault", fault, 0);
        @(negedge clk);
        @(negedge clk);
        rst_b = 1'b1;
        m_pc = 32'h0;
        m_halt = 0;
        m_fault = 0;
    endtask

    task automatic do_fetch(input logic [31:0] word, input int lat,
                            input bit stray);
        bit ok = 0;
        for (int i = 0; i < 20; i++) begin
            if (imem_req) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            check("req_timeout", 0, 1);
            return;
        end
        check("fetch_addr", imem_addr, m_pc);
        for (int i = 0; i < lat; i++) begin
            if (stray) begin
                ctl_valid = 1;
                jump = 1;
            end
            @(negedge clk);
            ctl_valid = 0;
            jump = 0;
        end
        imem_ack = 1;
        imem_rdata = word;
        @(negedge clk);
        imem_ack = 0;
        imem_rdata = $urandom;
        m_inst = word;
        check("issue_valid", inst_valid, 1);
        check("issue_inst", inst, word);
        check("issue_pc", pc, m_pc);
        check("link_addr", link_addr, m_pc + 32'd4);
        check("issue_req", imem_req, 0);
    endtask

    task automatic do_issue(input bit h, input bit jr, input bit j,
                            input bit br, input bit tk,
                            input logic [31:0] rs, input int lat,
                            input bit stray);
        for (int i = 0; i < lat; i++) begin
            if (stray) begin
                imem_ack = 1;
                imem_rdata = 32'hDEAD_BEEF;
            end
            @(negedge clk);
            imem_ack = 0;
        end
        if (lat > 0) check("hold_inst", inst, m_inst);
        halted = h;
        jump_reg = jr;
        jump = j;
        branch = br;
        branch_taken = tk;
        rs_data = rs;
        ctl_valid = 1;
        @(negedge clk);
        {halted, jump_reg, jump, branch, branch_taken, ctl_valid} = '0;
        rs_data = $urandom;
        model(h, jr, j, br, tk, rs);
        check("res_halt", halt, m_halt);
        check("res_fault", fault, m_fault);
        check("res_valid", inst_valid, 0);
        check("res_req", imem_req, !m_halt);
        check("res_pc", pc, m_pc);
    endtask

    task automatic poke_halt();
        for (int i = 0; i < 3; i++) begin
            imem_ack = 1;
            ctl_valid = 1;
            jump = 1;
            rs_data = 32'h40;
            @(negedge clk);
            {imem_ack, ctl_valid, jump} = '0;
            check("halt_stays", halt, 1);
            check("halt_pc", pc, m_pc);
            check("halt_req", imem_req, 0);
            check("halt_valid", inst_valid, 0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        rst_b = 1'b1;
        {imem_ack, ctl_valid, jump, jump_reg, branch, branch_taken, halted} = '0;
        imem_rdata = '0;
        rs_data = '0;
        w_ack = 0;
        w_ctl = 0;
        w_rdata = '0;
        m_inst = '0;
        @(negedge clk);
        do_reset();

        // reset vector wraps through 0 on the second instance
        @(negedge clk);
        check("w_first", w_addr, 32'hFFFF_FFFC);
        w_ack = 1;
        @(negedge clk);
        w_ack = 0;
        w_ctl = 1;
        @(negedge clk);
        w_ctl = 0;
        check("w_second", w_addr, 32'h0);
        check("w_req", w_req, 1);
        check("w_fault", w_fault, 0);

        // sequential zero-wait fetches, two cycles each
        do_fetch(32'h0, 0, 0);
        do_issue(0, 0, 0, 0, 0, 0, 0, 0);
        c0 = cyc;
        for (int i = 0; i < 3; i++) begin
            do_fetch(32'h0, 0, 0);
            do_issue(0, 0, 0, 0, 0, 0, 0, 0);
        end
        check("period", 32'(cyc - c0), 32'd6);

        // backward branch then not-taken at 0x10
        do_fetch(32'h1000_FFFC, 0, 0);
        do_issue(0, 0, 0, 1, 1, 0, 0, 0);
        check("br_back", pc, 32'h4);
        for (int i = 0; i < 3; i++) begin
            do_fetch(32'h0, 0, 0);
            do_issue(0, 0, 0, 0, 0, 0, 0, 0);
        end
        do_fetch(32'h1000_FFFC, 1, 0);
        do_issue(0, 0, 0, 1, 0, 0, 1, 0);
        check("br_not", pc, 32'h14);

        // absolute jump, then jump beating a taken branch
        do_fetch(32'h0, 0, 0);
        do_issue(0, 1, 0, 0, 0, 32'h1000_0000, 0, 0);
        do_fetch(32'h0800_0040, 0, 0);
        do_issue(0, 0, 1, 0, 0, 0, 0, 0);
        check("jump_tgt", pc, 32'h1000_0100);
        do_fetch(32'h0800_0040, 0, 0);
        do_issue(0, 0, 1, 1, 1, 0, 0, 0);
        check("jump_wins", pc, 32'h1000_0100);

        // misaligned jump_reg faults; aligned one fetches
        do_fetch(32'h0, 0, 0);
        do_issue(0, 1, 0, 0, 0, 32'h0000_0102, 0, 0);
        check("jr_fault", fault, 1);
        poke_halt();
        do_reset();
        do_fetch(32'h0, 0, 0);
        do_issue(0, 1, 0, 0, 0, 32'h0000_0200, 0, 0);
        check("jr_ok", imem_addr, 32'h200);

        // syscall outranks jump
        do_fetch(32'h0800_0040, 0, 0);
        do_issue(1, 0, 1, 0, 0, 0, 0, 0);
        check("sys_fault", fault, 0);
        poke_halt();

        // reset in the middle of a delayed fetch
        do_reset();
        @(negedge clk);
        check("mid_req", imem_req, 1);
        @(negedge clk);
        @(negedge clk);
        #2;
        rst_b = 1'b0;
        #1;
        check("mid_rst_req", imem_req, 0);
        check("mid_rst_pc", pc, 32'h0);
        check("mid_rst_valid", inst_valid, 0);
        @(negedge clk);
        rst_b = 1'b1;
        imem_ack = 1;
        imem_rdata = 32'hABCD_0123;
        @(negedge clk);
        imem_ack = 0;
        check("stray_valid", inst_valid, 0);
        check("stray_inst", inst, 32'h0);
        check("stray_req", imem_req, 1);
        check("stray_addr", imem_addr, 32'h0);
        m_pc = 32'h0;

        for (int n = 0; n < 300; n++) begin
            logic [31:0] rs;
            bit h, jr, j, br, tk;
            do_fetch($urandom, $urandom_range(0, 2), $urandom_range(0, 3) == 0);
            h  = ($urandom_range(0, 47) == 0);
            jr = ($urandom_range(0, 7) == 0);
            j  = ($urandom_range(0, 3) == 0);
            br = ($urandom_range(0, 2) == 0);
            tk = 1'($urandom);
            rs = $urandom;
            if ($urandom_range(0, 3) != 0) rs[1:0] = 2'b00;
            do_issue(h, jr, j, br, tk, rs, $urandom_range(0, 2),
                     $urandom_range(0, 1) == 1);
            if (m_halt) begin
                poke_halt();
                do_reset();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
